// File: rtl/fetch_stage_pkg.sv
// Shared widths and FSM encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_SIZE  = 31;
    localparam int unsigned INSTR_SIZE = 31;
    localparam int unsigned ADDR_W     = ADDR_SIZE + 1;
    localparam int unsigned INSTR_W    = INSTR_SIZE + 1;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction that arrives while decode stalls.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic                unload,
    input  logic [ADDR_SIZE:0]  load_pc,
    input  logic [INSTR_SIZE:0] load_instr,
    output logic                full,
    output logic [ADDR_SIZE:0]  buf_pc,
    output logic [INSTR_SIZE:0] buf_instr
);

    logic                full_q;
    logic [ADDR_SIZE:0]  pc_q;
    logic [INSTR_SIZE:0] instr_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            full_q <= 1'b1;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while full_q is set.
    always_ff @(posedge clk) begin
        if (load) begin
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end
    end

    assign full      = full_q;
    assign buf_pc    = pc_q;
    assign buf_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, registered output to decode,
// one-entry stall buffer, flush/redirect with dropping of a stale response.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_SIZE:0] RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_SIZE:0]  redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_SIZE:0]  imem_addr,
    input  logic                imem_resp_valid,
    input  logic [INSTR_SIZE:0] imem_resp_data,
    output logic [ADDR_SIZE:0]  PC_out,
    output logic [INSTR_SIZE:0] instr_out,
    output logic                pipeline_out_valid
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_SIZE:0]  pc_q, pc_d;
    logic [ADDR_SIZE:0]  pc_out_q, pc_out_d;
    logic [INSTR_SIZE:0] instr_out_q, instr_out_d;
    logic                valid_q, valid_d;

    logic                buf_full, buf_load, buf_unload;
    logic [ADDR_SIZE:0]  buf_pc;
    logic [INSTR_SIZE:0] buf_instr;
    logic                resp_take;

    assign imem_req_valid = (state_q == StReq) && !buf_full && !flush;
    assign imem_addr      = pc_q;
    assign resp_take      = (state_q == StWait) && imem_resp_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instr_out_d = instr_out_q;
        valid_d     = valid_q;
        buf_load    = 1'b0;
        buf_unload  = 1'b0;

        if (flush) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            // A request still in flight must have its response swallowed.
            if ((state_q != StReq) && !imem_resp_valid) begin
                state_d = StDrop;
            end else begin
                state_d = StReq;
            end
        end else begin
            case (state_q)
                StReq: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        state_d = StReq;
                        pc_d    = pc_q + ADDR_W'(PC_STEP);
                    end
                end
                StDrop: begin
                    if (imem_resp_valid) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StReq;
            endcase

            if (stall) begin
                buf_load = resp_take;
            end else if (buf_full) begin
                pc_out_d    = buf_pc;
                instr_out_d = buf_instr;
                valid_d     = 1'b1;
                buf_unload  = 1'b1;
            end else if (resp_take) begin
                pc_out_d    = pc_q;
                instr_out_d = imem_resp_data;
                valid_d     = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            pc_out_q    <= '0;
            instr_out_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            instr_out_q <= instr_out_d;
            valid_q     <= valid_d;
        end
    end

    fetch_skid_buf u_skid_buf (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (buf_load),
        .unload     (buf_unload),
        .load_pc    (pc_q),
        .load_instr (imem_resp_data),
        .full       (buf_full),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    assign PC_out             = pc_out_q;
    assign instr_out          = instr_out_q;
    assign pipeline_out_valid = valid_q;

endmodule
